// File: rtl/avalon_mem_responder_pkg.sv
// Shared constants, types and helpers for the Avalon-MM memory responder.
// Imported by the top-level responder and its read-return pipeline.
package avalon_mem_pkg;

  localparam int MAX_WAIT_CYCLES  = 15;
  localparam int MAX_READ_LATENCY = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rd_slot_t;

  // Word index from a byte address; bits [1:0] and everything above the array size drop out.
  function automatic logic [31:0] addr_to_index(input logic [31:0] addr, input int unsigned depth);
    return (addr >> 2) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/avalon_mem_responder_if.sv
// Avalon-MM single-word bus between a master and the memory responder.
// The responder is the slave side.
interface avalon_mem_responder_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avalon_mem_responder_rdpipe.sv
// Fixed-latency read-return shift register; data is zeroed in empty slots so
// readdata stays 0 whenever readdatavalid is low.
module avalon_rdpipe
  import avalon_mem_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        readdatavalid,
  output logic [31:0] readdata
);

  rd_slot_t slot_r [LATENCY];

  // Shift accepted read data toward the output; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        slot_r[i] <= '{valid: 1'b0, data: 32'd0};
      end
    end else begin
      slot_r[0] <= '{valid: in_valid, data: (in_valid ? in_data : 32'd0)};
      for (int i = 1; i < LATENCY; i++) begin
        slot_r[i] <= slot_r[i-1];
      end
    end
  end

  assign readdatavalid = slot_r[LATENCY-1].valid;
  assign readdata      = slot_r[LATENCY-1].data;

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave memory with configurable wait states and read latency,
// accept/error counters and a combinational debug peek port.
module avalon_mem_responder
  import avalon_mem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 256,
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  avalon_mem_responder_if.slave          slave,
  input  logic                           force_stall,
  output logic [31:0]                    reads_accepted,
  output logic [31:0]                    writes_accepted,
  output logic [31:0]                    proto_errors,
  input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_index,
  output logic [31:0]                    dbg_readdata
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LIMIT =
    4'((WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES);
  localparam int LAT =
    (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

  logic [31:0]      mem_r [DEPTH_WORDS];
  logic [3:0]       cnt_r;
  logic             req_s;
  logic             waitreq_s;
  logic             accept_s;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             proto_s;
  logic [IDX_W-1:0] idx_s;
  logic [31:0]      rd_capture_s;
  logic             rd_valid_s;
  logic [31:0]      rd_data_s;

  // A simultaneous read+write is served as a write only.
  always_comb begin
    req_s        = slave.read | slave.write;
    waitreq_s    = rst | force_stall | (req_s & (cnt_r < WAIT_LIMIT));
    accept_s     = req_s & ~waitreq_s;
    wr_acc_s     = accept_s & slave.write;
    rd_acc_s     = accept_s & slave.read & ~slave.write;
    proto_s      = accept_s & slave.read & slave.write;
    idx_s        = IDX_W'(addr_to_index(slave.address, 32'(DEPTH_WORDS)));
    rd_capture_s = rd_acc_s ? mem_r[idx_s] : 32'd0;
  end

  // Wait-state counter; force_stall freezes it so the stall resumes where it left off.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (!req_s || accept_s) begin
      cnt_r <= 4'd0;
    end else if (!force_stall && (cnt_r < WAIT_LIMIT)) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reads_accepted  <= 32'd0;
      writes_accepted <= 32'd0;
      proto_errors    <= 32'd0;
    end else begin
      reads_accepted  <= reads_accepted  + {31'd0, rd_acc_s};
      writes_accepted <= writes_accepted + {31'd0, wr_acc_s};
      proto_errors    <= proto_errors    + {31'd0, proto_s};
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[idx_s] <= slave.writedata;
    end
  end

  avalon_rdpipe #(
    .LATENCY (LAT)
  ) u_rdpipe (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (rd_acc_s),
    .in_data       (rd_capture_s),
    .readdatavalid (rd_valid_s),
    .readdata      (rd_data_s)
  );

  assign slave.waitrequest   = waitreq_s;
  assign slave.readdatavalid = rd_valid_s;
  assign slave.readdata      = rd_data_s;
  assign dbg_readdata        = mem_r[dbg_index];

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed bench for avalon_mem_responder: two instances (1 wait/2 latency and
// 0 wait/3 latency) with per-instance expected-return queues and a negedge monitor.
module tb_avalon_mem_responder;
  import avalon_mem_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs_a, fs_b;
  logic [7:0]  dbg_idx_a, dbg_idx_b;
  logic [31:0] dbg_a, dbg_b;
  logic [31:0] ra_a, wa_a, pe_a, ra_b, wa_b, pe_b;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  avalon_mem_responder_if ifa ();
  avalon_mem_responder_if ifb ();

  avalon_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1), .READ_LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .slave(ifa.slave), .force_stall(fs_a),
    .reads_accepted(ra_a), .writes_accepted(wa_a), .proto_errors(pe_a),
    .dbg_index(dbg_idx_a), .dbg_readdata(dbg_a)
  );

  avalon_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .READ_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .slave(ifb.slave), .force_stall(fs_b),
    .reads_accepted(ra_b), .writes_accepted(wa_b), .proto_errors(pe_b),
    .dbg_index(dbg_idx_b), .dbg_readdata(dbg_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Compare one instance's return port against the head of its expected queue.
  task automatic mon_one(input bit b);
    logic        v;
    logic [31:0] d;
    bit          ev;
    exp_t        e;
    string       pfx;
    pfx = b ? "b" : "a";
    v   = b ? ifb.readdatavalid : ifa.readdatavalid;
    d   = b ? ifb.readdata : ifa.readdata;
    if (b) ev = (exp_b.size() > 0) && (exp_b[0].due == cyc);
    else   ev = (exp_a.size() > 0) && (exp_a[0].due == cyc);
    check({pfx, "_rvalid"}, {31'd0, v}, {31'd0, ev});
    if (ev) begin
      if (b) e = exp_b.pop_front();
      else   e = exp_a.pop_front();
      check({pfx, "_rdata"}, d, e.data);
    end else begin
      check({pfx, "_rdata_idle"}, d, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_one(1'b0);
      mon_one(1'b1);
    end
  end

  // Issue one command, count stall cycles, queue the expected return if any.
  task automatic cmd(input bit b, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input int exp_waits, input bit ret);
    int    waits;
    bit    acc;
    string pfx;
    waits = 0;
    acc   = 1'b0;
    pfx   = b ? "b" : "a";
    if (b) begin
      ifb.address = addr; ifb.read = rd; ifb.write = wr; ifb.writedata = wdata;
    end else begin
      ifa.address = addr; ifa.read = rd; ifa.write = wr; ifa.writedata = wdata;
    end
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      if (b ? ifb.waitrequest : ifa.waitrequest) waits++;
      else acc = 1'b1;
    end
    check({pfx, "_wait_cycles"}, 32'(waits), 32'(exp_waits));
    if (acc && rd && !wr && ret) begin
      if (b) exp_b.push_back('{data: exp_rdata, due: cyc + 3});
      else   exp_a.push_back('{data: exp_rdata, due: cyc + 2});
    end
    @(posedge clk);
    #1;
    if (b) begin
      ifb.read = 1'b0; ifb.write = 1'b0;
    end else begin
      ifa.read = 1'b0; ifa.write = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fs_a = 1'b0; fs_b = 1'b0; dbg_idx_a = 8'd0; dbg_idx_b = 8'd0;
    ifa.address = 32'd0; ifa.read = 1'b0; ifa.write = 1'b0; ifa.writedata = 32'd0;
    ifb.address = 32'd0; ifb.read = 1'b0; ifb.write = 1'b0; ifb.writedata = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_waitreq", {31'd0, ifa.waitrequest}, 32'd1);
    check("rst_a_rvalid", {31'd0, ifa.readdatavalid}, 32'd0);
    check("rst_a_reads", ra_a, 32'd0);
    check("rst_a_writes", wa_a, 32'd0);
    check("rst_a_proto", pe_a, 32'd0);
    check("rst_b_waitreq", {31'd0, ifb.waitrequest}, 32'd1);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_a_waitreq", {31'd0, ifa.waitrequest}, 32'd0);
    check("idle_b_waitreq", {31'd0, ifb.waitrequest}, 32'd0);
    @(posedge clk);
    #1;

    // Instance A: one wait state, two-cycle read latency.
    cmd(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1, 1'b0);
    cmd(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1, 1'b1);
    idle(4);
    check("a_writes_1", wa_a, 32'd1);
    check("a_reads_1", ra_a, 32'd1);

    cmd(1'b0, 1'b0, 1'b1, 32'h24, 32'h0, 32'd0, 1, 1'b0);
    dbg_idx_a = 8'd9;
    fs_a = 1'b1;
    ifa.address = 32'h24; ifa.writedata = 32'h12345678; ifa.write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_waitreq", {31'd0, ifa.waitrequest}, 32'd1);
      check("stall_mem_held", dbg_a, 32'h0);
    end
    @(posedge clk);
    #1;
    fs_a = 1'b0;
    check("stall_writes_held", wa_a, 32'd2);
    cmd(1'b0, 1'b0, 1'b1, 32'h24, 32'h12345678, 32'd0, 1, 1'b0);
    check("stall_mem_after", dbg_a, 32'h12345678);

    cmd(1'b0, 1'b1, 1'b1, 32'h20, 32'h55, 32'd0, 1, 1'b0);
    dbg_idx_a = 8'd8;
    #1;
    check("proto_mem8", dbg_a, 32'h55);
    check("proto_count", pe_a, 32'd1);

    cmd(1'b0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 32'd0, 1, 1'b0);
    dbg_idx_a = 8'd0;
    #1;
    check("alias_mem0", dbg_a, 32'hA5A5A5A5);
    cmd(1'b0, 1'b1, 1'b0, 32'h3, 32'd0, 32'hA5A5A5A5, 1, 1'b1);
    idle(4);
    check("a_writes_end", wa_a, 32'd5);
    check("a_reads_end", ra_a, 32'd2);
    check("a_proto_end", pe_a, 32'd1);

    // Instance B: no wait states, three-cycle latency, back-to-back traffic.
    cmd(1'b1, 1'b0, 1'b1, 32'h0, 32'd1, 32'd0, 0, 1'b0);
    cmd(1'b1, 1'b0, 1'b1, 32'h4, 32'd2, 32'd0, 0, 1'b0);
    cmd(1'b1, 1'b0, 1'b1, 32'h8, 32'd3, 32'd0, 0, 1'b0);
    cmd(1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 32'd1, 0, 1'b1);
    cmd(1'b1, 1'b1, 1'b0, 32'h4, 32'd0, 32'd2, 0, 1'b1);
    cmd(1'b1, 1'b1, 1'b0, 32'h8, 32'd0, 32'd3, 0, 1'b1);
    cmd(1'b1, 1'b0, 1'b1, 32'hC, 32'h77, 32'd0, 0, 1'b0);
    cmd(1'b1, 1'b1, 1'b0, 32'hC, 32'd0, 32'h77, 0, 1'b1);
    idle(6);
    check("b_reads", ra_b, 32'd4);
    check("b_writes", wa_b, 32'd4);

    // Reset two cycles after a read accept must swallow the return.
    cmd(1'b1, 1'b1, 1'b0, 32'h4, 32'd0, 32'd0, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_b_waitreq", {31'd0, ifb.waitrequest}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(8);
    check("midrst_b_reads", ra_b, 32'd0);
    check("midrst_b_writes", wa_b, 32'd0);
    check("midrst_a_writes", wa_a, 32'd0);
    dbg_idx_b = 8'd1;
    #1;
    check("midrst_mem_kept", dbg_b, 32'd2);
    check("a_queue_empty", 32'(exp_a.size()), 32'd0);
    check("b_queue_empty", 32'(exp_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
